// File: rtl/ifetch_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel, redirect
// input from the datapath, and the {instruction, PC} delivery handshake.
interface ifetch_prefetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Request/response instruction fetch engine with a DEPTH-entry prefetch FIFO,
// in-order stale-response discard after redirects, and a valid/ready output.
module ifetch_prefetch_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          RESET_N,
    input logic          push,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] stale
);
    localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

    a_no_overflow: assert property (@(posedge clk) disable iff (!RESET_N)
        !(push && (count >= FULL)));
    a_stale_le_out: assert property (@(posedge clk) disable iff (!RESET_N)
        (stale <= outstanding) && (outstanding <= FULL));
endmodule

module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic               clk,
    input logic               RESET_N,
    ifetch_prefetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_SUM = DEPTH[CW:0];
    localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};

    logic [31:0]   fetch_pc_r, resp_pc_r, fetch_pc_nx_s, resp_pc_nx_s;
    logic [CW-1:0] outstanding_r, stale_r, count_r;
    logic [CW-1:0] outstanding_nx_s, stale_nx_s, count_nx_s;
    logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nx_s, wr_ptr_nx_s;
    logic [31:0]   instr_mem_r [DEPTH];
    logic [31:0]   pc_mem_r    [DEPTH];
    logic          run_r;
    logic [CW:0]   sum_s;
    logic          req_s, issue_s, resp_s, drop_s, push_s, pop_s, valid_s;
    logic [31:0]   redirect_base_s;
    logic          unused_pc_bits_s;

    assign unused_pc_bits_s = ^bus.redirect_pc[1:0];

    // Handshake qualification; responses during a redirect cycle are always dropped.
    always_comb begin
        sum_s           = {1'b0, outstanding_r} + {1'b0, count_r};
        req_s           = run_r & (sum_s < DEPTH_SUM) & ~bus.redirect;
        issue_s         = req_s & bus.imem_gnt;
        resp_s          = bus.imem_rvalid & (outstanding_r != ZERO_CNT);
        drop_s          = resp_s & ((stale_r != ZERO_CNT) | bus.redirect);
        push_s          = resp_s & ~drop_s;
        valid_s         = (count_r != ZERO_CNT);
        pop_s           = valid_s & bus.id_ready & ~bus.redirect;
        redirect_base_s = {bus.redirect_pc[31:2], 2'b00};
    end

    // Next-state for PCs, counters and FIFO pointers.
    always_comb begin
        fetch_pc_nx_s    = fetch_pc_r;
        resp_pc_nx_s     = resp_pc_r;
        stale_nx_s       = stale_r;
        count_nx_s       = count_r;
        rd_ptr_nx_s      = rd_ptr_r;
        wr_ptr_nx_s      = wr_ptr_r;
        outstanding_nx_s = outstanding_r + CW'(issue_s) - CW'(resp_s);
        if (bus.redirect) begin
            fetch_pc_nx_s = redirect_base_s;
            resp_pc_nx_s  = redirect_base_s;
            stale_nx_s    = outstanding_r - CW'(resp_s);
            count_nx_s    = ZERO_CNT;
            rd_ptr_nx_s   = {AW{1'b0}};
            wr_ptr_nx_s   = {AW{1'b0}};
        end else begin
            if (issue_s) begin
                fetch_pc_nx_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_nx_s = fetch_pc_r;
            end
            if (drop_s) begin
                stale_nx_s = stale_r - CW'(1'b1);
            end else begin
                stale_nx_s = stale_r;
            end
            if (push_s) begin
                resp_pc_nx_s = resp_pc_r + 32'd4;
                wr_ptr_nx_s  = wr_ptr_r + AW'(1'b1);
            end else begin
                resp_pc_nx_s = resp_pc_r;
                wr_ptr_nx_s  = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nx_s = rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end
            count_nx_s = count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers; run_r holds requests off until the first edge after reset release.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            run_r         <= 1'b0;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= ZERO_CNT;
            stale_r       <= ZERO_CNT;
            count_r       <= ZERO_CNT;
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
        end else begin
            run_r         <= 1'b1;
            fetch_pc_r    <= fetch_pc_nx_s;
            resp_pc_r     <= resp_pc_nx_s;
            outstanding_r <= outstanding_nx_s;
            stale_r       <= stale_nx_s;
            count_r       <= count_nx_s;
            rd_ptr_r      <= rd_ptr_nx_s;
            wr_ptr_r      <= wr_ptr_nx_s;
        end
    end

    // FIFO storage of {instruction, PC} pairs.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
            pc_mem_r[wr_ptr_r]    <= resp_pc_r;
        end else begin
            instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
            pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
        end
    end

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.id_valid  = valid_s;
    assign bus.id_instr  = valid_s ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign bus.id_pc     = valid_s ? pc_mem_r[rd_ptr_r]    : 32'h0000_0000;

    ifetch_prefetch_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk         (clk),
        .RESET_N     (RESET_N),
        .push        (push_s),
        .count       (count_r),
        .outstanding (outstanding_r),
        .stale       (stale_r)
    );
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with an in-order, fixed-latency memory model.
module tb_ifetch_prefetch;
    logic clk;
    logic RESET_N;
    int   total = 0;
    int   bad   = 0;

    ifetch_prefetch_if bus ();

    ifetch_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } txn_t;

    txn_t        pend[$];
    int          edge_cnt  = 0;
    int          grant_cnt = 0;
    int          lat       = 1;
    logic [31:0] delivered[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: records grants on the rising edge, presents due responses after the falling edge.
    always @(posedge clk or negedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pend.delete();
            grant_cnt        = 0;
            bus.imem_rvalid  = 1'b0;
            bus.imem_rdata   = 32'h0000_0000;
        end else if (clk) begin
            edge_cnt++;
            if (bus.imem_req && bus.imem_gnt) begin
                pend.push_back('{bus.imem_addr, edge_cnt + lat});
                grant_cnt++;
            end
        end else begin
            if (pend.size() != 0 && pend[0].due <= edge_cnt + 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = instr_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'h0000_0000;
            end
        end
    end

    // Record every PC actually consumed by the datapath.
    always @(posedge clk) begin
        if (RESET_N && bus.id_valid && bus.id_ready && !bus.redirect)
            delivered.push_back(bus.id_pc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int base;

    initial begin
        RESET_N         = 1'b0;
        bus.imem_gnt    = 1'b1;
        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0000_0000;
        lat             = 1;

        // Reset state
        repeat (2) step();
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0000_0000);
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_instr", bus.id_instr, 32'h0000_0000);
        chk("rst_pc",    bus.id_pc, 32'h0000_0000);

        // Streaming, latency 1, then redirect coinciding with rvalid and a pop
        RESET_N = 1'b1;
        base = delivered.size();
        step();
        chk("t1_req",    {31'd0, bus.imem_req}, 32'd1);
        chk("t1_addr0",  bus.imem_addr, 32'h0000_0000);
        chk("t1_nv0",    {31'd0, bus.id_valid}, 32'd0);
        step();
        chk("t1_addr4",  bus.imem_addr, 32'h0000_0004);
        chk("t1_nv1",    {31'd0, bus.id_valid}, 32'd0);
        step();
        chk("t1_valid",  {31'd0, bus.id_valid}, 32'd1);
        chk("t1_pc0",    bus.id_pc, 32'h0000_0000);
        chk("t1_instr0", bus.id_instr, instr_of(32'h0000_0000));
        chk("t1_addr8",  bus.imem_addr, 32'h0000_0008);
        step();
        chk("t1_pc4",    bus.id_pc, 32'h0000_0004);
        step();
        chk("t1_pc8",    bus.id_pc, 32'h0000_0008);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        #1;
        chk("t4_req_forced", {31'd0, bus.imem_req}, 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        chk("t4_valid_flush", {31'd0, bus.id_valid}, 32'd0);
        chk("t4_addr200",     bus.imem_addr, 32'h0000_0200);
        step();
        chk("t4_nv",          {31'd0, bus.id_valid}, 32'd0);
        step();
        chk("t4_pc200",       bus.id_pc, 32'h0000_0200);
        chk("t4_instr200",    bus.id_instr, instr_of(32'h0000_0200));
        step();
        chk("t4_pc204",       bus.id_pc, 32'h0000_0204);
        step();
        chk("t4_ndeliv",      delivered.size() - base, 32'd4);
        chk("t4_d1",          delivered[base + 1], 32'h0000_0004);
        chk("t4_d2",          delivered[base + 2], 32'h0000_0200);
        chk("t4_d3",          delivered[base + 3], 32'h0000_0204);

        // Backpressure, latency 3: FIFO fills, one pop frees one slot
        RESET_N = 1'b0;
        lat = 3;
        bus.id_ready = 1'b0;
        step();
        RESET_N = 1'b1;
        repeat (9) step();
        chk("t2_grants4", grant_cnt, 32'd4);
        chk("t2_req_off", {31'd0, bus.imem_req}, 32'd0);
        chk("t2_head",    bus.id_pc, 32'h0000_0000);
        chk("t2_addr10",  bus.imem_addr, 32'h0000_0010);
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        #1;
        chk("t2_head4",   bus.id_pc, 32'h0000_0004);
        chk("t2_req_on",  {31'd0, bus.imem_req}, 32'd1);
        chk("t2_addr10b", bus.imem_addr, 32'h0000_0010);
        step();
        chk("t2_req_off2", {31'd0, bus.imem_req}, 32'd0);
        chk("t2_grants5",  grant_cnt, 32'd5);
        chk("t2_addr14",   bus.imem_addr, 32'h0000_0014);

        // Redirect with 3 outstanding and one FIFO entry
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        repeat (5) step();
        chk("t3_pre_pc", bus.id_pc, 32'h0000_0000);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        step();
        bus.redirect = 1'b0;
        #1;
        chk("t3_flush",   {31'd0, bus.id_valid}, 32'd0);
        chk("t3_req",     {31'd0, bus.imem_req}, 32'd1);
        chk("t3_addr100", bus.imem_addr, 32'h0000_0100);
        repeat (3) step();
        chk("t3_stale_dropped", {31'd0, bus.id_valid}, 32'd0);
        step();
        chk("t3_pc100",    bus.id_pc, 32'h0000_0100);
        chk("t3_instr100", bus.id_instr, instr_of(32'h0000_0100));
        bus.id_ready = 1'b1;
        step();
        chk("t3_pc104",    bus.id_pc, 32'h0000_0104);

        // Grant withheld, then address wrap
        RESET_N = 1'b0;
        lat = 1;
        bus.imem_gnt = 1'b0;
        step();
        RESET_N = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("t5_hold_addr", bus.imem_addr, 32'h0000_0000);
            step();
        end
        bus.imem_gnt = 1'b1;
        step();
        chk("t5_adv",  bus.imem_addr, 32'h0000_0004);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        #1;
        chk("t5_req_forced", {31'd0, bus.imem_req}, 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        chk("t5_addrFF8", bus.imem_addr, 32'hFFFF_FFF8);
        step();
        chk("t5_addrFFC", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap",    bus.imem_addr, 32'h0000_0000);
        chk("t5_pcFF8",   bus.id_pc, 32'hFFFF_FFF8);
        step();
        chk("t5_pcFFC",   bus.id_pc, 32'hFFFF_FFFC);
        step();
        chk("t5_pc_wrap", bus.id_pc, 32'h0000_0000);
        chk("t5_instr0",  bus.id_instr, instr_of(32'h0000_0000));

        // Asynchronous reset mid-burst with 2 outstanding
        RESET_N = 1'b0;
        lat = 2;
        bus.id_ready = 1'b0;
        step();
        RESET_N = 1'b1;
        repeat (4) step();
        chk("t6_pre_valid", {31'd0, bus.id_valid}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("t6_req_low",   {31'd0, bus.imem_req}, 32'd0);
        chk("t6_valid_low", {31'd0, bus.id_valid}, 32'd0);
        chk("t6_pc_zero",   bus.id_pc, 32'h0000_0000);
        chk("t6_addr_rst",  bus.imem_addr, 32'h0000_0000);
        step();
        lat = 1;
        bus.id_ready = 1'b1;
        step();
        RESET_N = 1'b1;
        step();
        chk("t6_restart",   bus.imem_addr, 32'h0000_0000);
        chk("t6_empty",     {31'd0, bus.id_valid}, 32'd0);
        step();
        chk("t6_empty2",    {31'd0, bus.id_valid}, 32'd0);
        step();
        chk("t6_pc0",       bus.id_pc, 32'h0000_0000);
        chk("t6_valid",     {31'd0, bus.id_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
